// File: rtl/reg_alu_pkg.sv
// Shared constants for the register-to-register execute/writeback stage:
// op codes, op width and the sequencer state encoding.
package reg_alu_pkg;

  localparam int OP_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] OP_ADD = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_AND = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_OR  = 3'd3;
  localparam logic [OP_WIDTH-1:0] OP_XOR = 3'd4;
  localparam logic [OP_WIDTH-1:0] OP_MOV = 3'd5;
  localparam logic [OP_WIDTH-1:0] OP_LDI = 3'd6;
  localparam logic [OP_WIDTH-1:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/reg_alu.sv
// Combinational ALU: result, carry (ADD carry-out / SUB borrow) and zero flag.
module reg_alu
  import reg_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;

  // The extra top bit of the widened difference is the unsigned borrow.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_WIDTH-1:0];
        carry  = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        result = diff[DATA_WIDTH-1:0];
        carry  = diff[DATA_WIDTH];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      OP_NOP:  result = '0;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/reg_alu_ctrl.sv
// Execute/writeback sequencer: accepts one command, reads both operands from
// reg_file, runs the ALU and writes the result back, one command per 4 cycles.
module reg_alu_ctrl
  import reg_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_WIDTH-1:0]   cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] cmd_rs2,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic [ADDR_WIDTH-1:0] rf_read_addr1,
  output logic [ADDR_WIDTH-1:0] rf_read_addr2,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic [DATA_WIDTH-1:0] rf_read_data2,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag_zero,
  output logic                  flag_carry
);

  state_t                  state;
  logic [OP_WIDTH-1:0]     op_q;
  logic [ADDR_WIDTH-1:0]   rd_q;
  logic [ADDR_WIDTH-1:0]   rs1_q;
  logic [ADDR_WIDTH-1:0]   rs2_q;
  logic [DATA_WIDTH-1:0]   imm_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    zero_q;
  logic                    carry_q;
  logic                    ready_q;
  logic                    we_q;
  logic                    done_q;

  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    alu_carry;
  logic                    alu_zero;

  reg_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Sequencer FSM with all capture, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ready_q  <= 1'b1;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            rd_q    <= cmd_rd;
            rs1_q   <= cmd_rs1;
            rs2_q   <= cmd_rs2;
            imm_q   <= cmd_imm;
            ready_q <= 1'b0;
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          a_q   <= rf_read_data1;
          b_q   <= rf_read_data2;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          // NOP leaves result and flags untouched but still reports completion.
          if (op_q != OP_NOP) begin
            result_q <= alu_result;
            zero_q   <= alu_zero;
            carry_q  <= alu_carry;
            we_q     <= 1'b1;
          end
          done_q <= 1'b1;
          state  <= ST_WB;
        end
        ST_WB: begin
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Reset in the WB cycle must suppress both the write and the completion pulse.
  assign rf_we         = we_q & ~rst;
  assign done          = done_q & ~rst;
  assign cmd_ready     = ready_q;
  assign rf_read_addr1 = rs1_q;
  assign rf_read_addr2 = rs2_q;
  assign rf_write_addr = rd_q;
  assign rf_write_data = result_q;
  assign result        = result_q;
  assign flag_zero     = zero_q;
  assign flag_carry    = carry_q;

endmodule

// File: tb/tb_reg_alu_ctrl.sv
// Self-checking bench for reg_alu_ctrl with a behavioural reg_file and a
// command-level timeline model compared against the DUT every cycle.
module tb_reg_alu_ctrl;
  import reg_alu_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [AW-1:0] cmd_rd = 3'd0;
  logic [AW-1:0] cmd_rs1 = 3'd0;
  logic [AW-1:0] cmd_rs2 = 3'd0;
  logic [DW-1:0] cmd_imm = 8'h00;
  logic [AW-1:0] rf_read_addr1, rf_read_addr2, rf_write_addr;
  logic [DW-1:0] rf_read_data1, rf_read_data2, rf_write_data;
  logic          rf_we, done, flag_zero, flag_carry;
  logic [DW-1:0] result;

  reg_alu_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_rd        (cmd_rd),
    .cmd_rs1       (cmd_rs1),
    .cmd_rs2       (cmd_rs2),
    .cmd_imm       (cmd_imm),
    .rf_read_addr1 (rf_read_addr1),
    .rf_read_addr2 (rf_read_addr2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .rf_we         (rf_we),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .done          (done),
    .result        (result),
    .flag_zero     (flag_zero),
    .flag_carry    (flag_carry)
  );

  always #5 clk = ~clk;

  // Behavioural register file: combinational reads, write on posedge.
  logic [DW-1:0] rf [8] = '{default: 8'h00};
  assign rf_read_data1 = rf[rf_read_addr1];
  assign rf_read_data2 = rf[rf_read_addr2];
  always @(posedge clk) if (rf_we) rf[rf_write_addr] <= rf_write_data;

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Architectural ALU from plain integer arithmetic; returns {carry, result}.
  function automatic logic [8:0] model_alu(input int op, input int a, input int b, input int imm);
    int r;
    logic c;
    r = 0;
    c = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 255); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a;
      6: r = imm;
      default: r = 0;
    endcase
    return {c, 8'(r & 255)};
  endfunction

  // Timeline model: accept, then result visible 2 cycles later, write cycle, idle.
  logic [DW-1:0] mref [8] = '{default: 8'h00};
  logic          m_busy = 1'b0;
  int            m_age = 0;
  logic [2:0]    m_op = 3'd0;
  logic [AW-1:0] m_rd = 3'd0, m_rs1 = 3'd0, m_rs2 = 3'd0;
  logic [DW-1:0] p_res = 8'h00, m_res = 8'h00;
  logic          p_c = 1'b0, m_c = 1'b0, m_z = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_age <= 0; m_op <= 3'd0;
      m_rd <= 3'd0; m_rs1 <= 3'd0; m_rs2 <= 3'd0;
      m_res <= 8'h00; m_c <= 1'b0; m_z <= 1'b0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy <= 1'b1; m_age <= 0; m_op <= cmd_op;
        m_rd <= cmd_rd; m_rs1 <= cmd_rs1; m_rs2 <= cmd_rs2;
        {p_c, p_res} <= model_alu(int'(cmd_op), int'(mref[cmd_rs1]), int'(mref[cmd_rs2]), int'(cmd_imm));
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age == 1 && m_op != 3'd7) begin
        m_res <= p_res; m_c <= p_c; m_z <= (p_res == 8'h00);
      end
      if (m_age == 2) begin
        m_busy <= 1'b0;
        if (m_op != 3'd7) mref[m_rd] <= m_res;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", int'(cmd_ready), int'(!m_busy));
      check("rf_we", int'(rf_we), int'(m_busy && m_age == 2 && m_op != 3'd7 && !rst));
      check("done", int'(done), int'(m_busy && m_age == 2 && !rst));
      check("result", int'(result), int'(m_res));
      check("flag_zero", int'(flag_zero), int'(m_z));
      check("flag_carry", int'(flag_carry), int'(m_c));
      check("rf_read_addr1", int'(rf_read_addr1), int'(m_rs1));
      check("rf_read_addr2", int'(rf_read_addr2), int'(m_rs2));
      check("rf_write_addr", int'(rf_write_addr), int'(m_rd));
      check("rf_write_data", int'(rf_write_data), int'(m_res));
    end
  end

  time t_acc = 0;

  task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int imm, input bit keep);
    bit got;
    got = 1'b0;
    cmd_op = 3'(op); cmd_rd = 3'(rd); cmd_rs1 = 3'(rs1); cmd_rs2 = 3'(rs2); cmd_imm = 8'(imm);
    cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      t_acc = $time;
      #1;
      if (!keep) cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    bit found;
    n = 0; found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n++;
      if (done) begin found = 1'b1; break; end
    end
    check("done_latency", found ? n : -1, 3);
  endtask

  task automatic run(input int op, input int rd, input int rs1, input int rs2, input int imm);
    issue(op, rd, rs1, rs2, imm, 1'b0);
    wait_done();
    @(posedge clk);
    #1;
  endtask

  time t1, t2, t3;

  initial begin
    // Reset wins over a simultaneous command.
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_rd = 3'd1; cmd_imm = 8'h77;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; cmd_valid = 1'b0;
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_result", int'(result), 0);

    run(6, 3, 0, 0, 8'hAA);
    check("ldi_r3", int'(rf[3]), 8'hAA);
    run(6, 5, 0, 0, 8'h55);
    run(0, 6, 3, 5, 0);
    check("add_res", int'(result), 8'hFF);
    check("add_carry", int'(flag_carry), 0);
    check("add_zero", int'(flag_zero), 0);
    check("add_r6", int'(rf[6]), 8'hFF);
    run(0, 7, 6, 6, 0);
    check("add2_res", int'(result), 8'hFE);
    check("add2_carry", int'(flag_carry), 1);
    run(1, 1, 5, 3, 0);
    check("sub_res", int'(result), 8'hAB);
    check("sub_carry", int'(flag_carry), 1);
    run(1, 2, 3, 3, 0);
    check("sub0_res", int'(result), 8'h00);
    check("sub0_zero", int'(flag_zero), 1);
    check("sub0_carry", int'(flag_carry), 0);
    run(4, 3, 3, 5, 0);
    check("xor_r3", int'(rf[3]), 8'hFF);
    run(7, 0, 1, 2, 8'h12);
    check("nop_res", int'(result), 8'hFF);
    check("nop_r0", int'(rf[0]), 8'h00);

    // Back-to-back with cmd_valid held high.
    issue(5, 0, 5, 0, 0, 1'b1); t1 = t_acc;
    issue(2, 4, 3, 5, 0, 1'b1); t2 = t_acc;
    issue(3, 2, 1, 5, 0, 1'b0); t3 = t_acc;
    check("b2b_gap1", int'(t2 - t1), 40);
    check("b2b_gap2", int'(t3 - t2), 40);
    wait_done();
    @(posedge clk);
    #1;
    check("mov_r0", int'(rf[0]), 8'h55);
    check("and_r4", int'(rf[4]), 8'h55);
    check("or_r2", int'(rf[2]), 8'hFF);

    // Reset during the WB cycle of ADD r4 = r5 + r5.
    issue(0, 4, 5, 5, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("wbrst_we", int'(rf_we), 0);
    check("wbrst_done", int'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("wbrst_r4", int'(rf[4]), 8'h55);
    check("wbrst_result", int'(result), 0);
    check("wbrst_ready", int'(cmd_ready), 1);
    check("wbrst_waddr", int'(rf_write_addr), 0);
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
